alu_rr_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit combinational ALU (module alu) between two requesters. It accepts one operation at a time through a valid/ready handshake, latches the operands, and executes the operation on the shared ALU. It registers the result and holds it on a response channel, tagged with the requester ID, until the response is accepted. It sits between two client FSMs and the single ALU instance, which it instantiates internally.

---
 rtl/alu_rr_sched_if.sv | 23 ++
 rtl/alu_rr_sched.sv | 121 ++++++++++++
 tb/tb_alu_rr_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_rr_sched_if.sv
// rtl/alu_rr_sched_if.sv - request/response bundle between two clients and the shared-ALU scheduler
interface alu_rr_sched_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [5:0] req_sel;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_out;
  logic       rsp_ov;
  logic       rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_ov, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_ov, rsp_id
  );
endinterface

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin scheduler sharing one 4-bit ALU between two requesters
module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  output logic [3:0] out,
  output logic       ov
);
  logic [4:0] r;
  logic [3:0] shl;
  logic [3:0] shr;

  always_comb begin
    shl = a << b[1:0];
    shr = a >> b[1:0];
    r   = 5'd0;
    case (sel)
      3'b000: r = {1'b0, a} + {1'b0, b};
      3'b001: r = {1'b0, a} - {1'b0, b};
      3'b010: r = {1'b0, a & b};
      3'b011: r = {1'b0, a | b};
      3'b100: r = {1'b0, a ^ b};
      3'b101: r = (b[3:2] != 2'b00) ? 5'd0 : {1'b0, shl};
      3'b110: r = (b[3:2] != 2'b00) ? 5'd0 : {1'b0, shr};
      default: r = {1'b0, a[2:0], a[3]};
    endcase
  end

  assign out = r[3:0];
  assign ov  = r[4];
endmodule

module alu_rr_sched #(
  parameter int CNT_W     = 8,
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_sched_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, next;
  logic [1:0] gnt;
  logic       ptr;
  logic [3:0] la, lb;
  logic [2:0] lsel;
  logic       lid;
  logic [3:0] alu_out;
  logic       alu_ov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // ptr names the requester that wins when both are valid
  always_comb begin
    next = state;
    gnt  = 2'b00;
    case (state)
      IDLE: begin
        case (bus.req_valid)
          2'b01:   gnt = 2'b01;
          2'b10:   gnt = 2'b10;
          2'b11:   gnt = ptr ? 2'b10 : 2'b01;
          default: gnt = 2'b00;
        endcase
        if (gnt != 2'b00) next = EXEC;
      end
      EXEC:    next = RESP;
      RESP:    if (bus.rsp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state == RESP);
  assign busy          = (state != IDLE);

  alu u_alu (
    .a   (la),
    .b   (lb),
    .sel (lsel),
    .out (alu_out),
    .ov  (alu_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      la          <= 4'd0;
      lb          <= 4'd0;
      lsel        <= 3'd0;
      lid         <= 1'b0;
      bus.rsp_out <= 4'd0;
      bus.rsp_ov  <= 1'b0;
      bus.rsp_id  <= 1'b0;
      ptr         <= FIRST_PRI;
      ops_done    <= '0;
    end else begin
      if (state == IDLE && gnt != 2'b00) begin
        lid  <= gnt[1];
        la   <= gnt[1] ? bus.req_a[7:4]   : bus.req_a[3:0];
        lb   <= gnt[1] ? bus.req_b[7:4]   : bus.req_b[3:0];
        lsel <= gnt[1] ? bus.req_sel[5:3] : bus.req_sel[2:0];
      end
      if (state == EXEC) begin
        bus.rsp_out <= alu_out;
        bus.rsp_ov  <= alu_ov;
        bus.rsp_id  <= lid;
      end
      // last-served requester drops to lowest priority
      if (state == RESP && bus.rsp_ready) begin
        ops_done <= ops_done + 1'b1;
        ptr      <= ~lid;
      end
    end
  end
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - directed and randomized checks of alu_rr_sched against a behavioural model
module tb_alu_rr_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] ops_done;

  alu_rr_sched_if bif();

  alu_rr_sched #(.CNT_W(8), .FIRST_PRI(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif.slave),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         ptr_m = 0;
  logic [7:0] ops_m = 8'd0;
  time        t0;

  function automatic logic [4:0] alu_ref(int a, int b, int sel);
    case (sel)
      0: return 5'(a + b);
      1: return 5'((a - b + 32) % 32);
      2: return 5'(a & b);
      3: return 5'(a | b);
      4: return 5'(a ^ b);
      5: return (b >= 4) ? 5'd0 : 5'((a * (1 << b)) % 16);
      6: return (b >= 4) ? 5'd0 : 5'(a / (1 << b));
      default: return 5'(((a * 2) % 16) + (a / 8));
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bif.req_a   = 8'($urandom);
    bif.req_b   = 8'($urandom);
    bif.req_sel = 6'($urandom);
  endtask

  // Entered and left #1 after a rising edge with the scheduler idle.
  task automatic do_op(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] sel, input int hold, input bit keep);
    int         id;
    logic [4:0] r;
    bif.req_valid = v;
    bif.req_a     = a;
    bif.req_b     = b;
    bif.req_sel   = sel;
    id = (v == 2'b11) ? ptr_m : (v[1] ? 1 : 0);
    r  = alu_ref(int'(a >> (4 * id)) % 16, int'(b >> (4 * id)) % 16, int'(sel >> (3 * id)) % 8);
    @(negedge clk);
    check("req_ready_grant", 8'(bif.req_ready), 8'(2'b01 << id));
    @(posedge clk); #1;
    if (!keep) bif.req_valid = 2'b00;
    scramble();
    check("busy_exec", 8'(busy), 8'd1);
    check("req_ready_exec", 8'(bif.req_ready), 8'd0);
    @(posedge clk); #1;
    check("rsp_valid", 8'(bif.rsp_valid), 8'd1);
    check("rsp_out", 8'(bif.rsp_out), 8'(r[3:0]));
    check("rsp_ov", 8'(bif.rsp_ov), 8'(r[4]));
    check("rsp_id", 8'(bif.rsp_id), 8'(id));
    for (int i = 0; i < hold; i++) begin
      bif.rsp_ready = 1'b0;
      scramble();
      @(posedge clk); #1;
      check("hold_valid", 8'(bif.rsp_valid), 8'd1);
      check("hold_out", 8'(bif.rsp_out), 8'(r[3:0]));
      check("hold_ov", 8'(bif.rsp_ov), 8'(r[4]));
      check("hold_id", 8'(bif.rsp_id), 8'(id));
      check("hold_ready", 8'(bif.req_ready), 8'd0);
      check("hold_busy", 8'(busy), 8'd1);
    end
    bif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;
    ptr_m = 1 - id;
    ops_m = ops_m + 8'd1;
    check("rsp_drop", 8'(bif.rsp_valid), 8'd0);
    check("busy_idle", 8'(busy), 8'd0);
    check("ops_done", ops_done, ops_m);
  endtask

  initial begin
    logic [1:0] v;
    bif.req_valid = 2'b00;
    bif.rsp_ready = 1'b0;
    scramble();
    #12;
    check("rst_rsp_valid", 8'(bif.rsp_valid), 8'd0);
    check("rst_rsp_out", 8'(bif.rsp_out), 8'd0);
    check("rst_ready", 8'(bif.req_ready), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_ops", ops_done, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // requester 0 add with carry, then requester 1 subtract with borrow
    do_op(2'b01, 8'h09, 8'h08, 6'b000_000, 0, 1'b0);
    do_op(2'b10, 8'h30, 8'h50, 6'b001_000, 0, 1'b0);

    // both valid continuously: alternating grants, 3 cycles per operation
    ptr_m = 0;
    t0 = $time;
    for (int i = 0; i < 4; i++)
      do_op(2'b11, 8'($urandom), 8'($urandom), 6'($urandom), 0, 1'b1);
    check("throughput_cycles", 8'(($time - t0) / 10), 8'd12);
    bif.req_valid = 2'b00;

    // backpressure
    do_op(2'b01, 8'h07, 8'h0C, 6'b000_011, 5, 1'b0);

    // shift and rotate edges
    do_op(2'b01, 8'h09, 8'h04, 6'b000_101, 0, 1'b0);
    do_op(2'b01, 8'h09, 8'h01, 6'b000_110, 0, 1'b0);
    do_op(2'b01, 8'h09, 8'h07, 6'b000_111, 0, 1'b0);

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      v = 2'($urandom_range(1, 3));
      do_op(v, 8'($urandom), 8'($urandom), 6'($urandom), $urandom_range(0, 2), 1'b0);
    end

    // make sure pointer is at 1 before reset so the reset value is observable
    do_op(2'b01, 8'($urandom), 8'($urandom), 6'($urandom), 0, 1'b0);
    bif.req_valid = 2'b10;
    @(posedge clk); #1;
    bif.req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 8'(bif.rsp_valid), 8'd0);
    check("arst_rsp_out", 8'(bif.rsp_out), 8'd0);
    check("arst_rsp_ov", 8'(bif.rsp_ov), 8'd0);
    check("arst_rsp_id", 8'(bif.rsp_id), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_ops", ops_done, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    ops_m = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_stale_rsp", 8'(bif.rsp_valid), 8'd0);
    end
    do_op(2'b11, 8'($urandom), 8'($urandom), 6'($urandom), 0, 1'b0);

    // counter wrap
    while (ops_m != 8'd255)
      do_op(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 6'($urandom), 0, 1'b0);
    check("ops_full", ops_done, 8'd255);
    do_op(2'b10, 8'($urandom), 8'($urandom), 6'($urandom), 0, 1'b0);
    check("ops_wrap", ops_done, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
